// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: opcodes, FSM
// state encoding, next-PC select and instruction field positions.
package fde_pkg;

  localparam int unsigned DEF_PC_W    = 16;
  localparam int unsigned DEF_INSTR_W = 40;
  localparam int unsigned DEF_OP_W    = 8;

  // Instruction layout: opcode[39:32], arg1[31:16], arg2[15:0]
  localparam int unsigned OP_MSB   = 39;
  localparam int unsigned OP_LSB   = 32;
  localparam int unsigned ARG1_MSB = 31;
  localparam int unsigned ARG1_LSB = 16;
  localparam int unsigned ARG2_MSB = 15;
  localparam int unsigned ARG2_LSB = 0;

  localparam logic [DEF_OP_W-1:0] OP_NOP  = 8'h00;
  localparam logic [DEF_OP_W-1:0] OP_JMP  = 8'h09;
  localparam logic [DEF_OP_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_UPDATE,
    ST_HALT
  } fde_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP
  } pc_sel_t;

endpackage

// File: rtl/fde_sequencer_if.sv
// ROM fetch and execute-unit handshake bundle between the sequencer (master)
// and the program ROM / execute unit (slave).
interface fde_sequencer_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 40,
  parameter int unsigned OP_W    = 8
);
  logic               rom_req;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               rom_valid;
  logic               exec_start;
  logic               exec_done;
  logic [PC_W-1:0]    exec_result;
  logic [OP_W-1:0]    opcode;
  logic [15:0]        arg1;
  logic [15:0]        arg2;

  modport master (
    output rom_req, rom_addr, exec_start, opcode, arg1, arg2,
    input  rom_data, rom_valid, exec_done, exec_result
  );

  modport slave (
    input  rom_req, rom_addr, exec_start, opcode, arg1, arg2,
    output rom_data, rom_valid, exec_done, exec_result
  );
endinterface

// File: rtl/fde_pc_unit.sv
// Program counter register with wrap-around incrementer and next-PC mux
// (hold / increment / jump).
module fde_pc_unit
  import fde_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  pc_sel_t         i_sel,
  input  logic [PC_W-1:0] i_jump,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    case (i_sel)
      PC_INC:  w_pc_next = r_pc + PC_W'(1);
      PC_JUMP: w_pc_next = i_jump;
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fde_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC and IR, fetches from
// ROM, starts the execute unit and selects the next PC.
// Optional: define FDE_DIRECT_JUMP_EN to resolve JMP in DECODE from arg1.
module fde_sequencer
  import fde_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned OP_W    = DEF_OP_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  fde_sequencer_if.master   bus,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              busy
);

  fde_state_t         r_state;
  fde_state_t         w_state_next;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_jump;
  logic               r_exec_first;

  logic               w_ir_load;
  logic               w_jump_load;
  logic [PC_W-1:0]    w_jump_next;
  pc_sel_t            w_pc_sel;
  logic [OP_W-1:0]    w_opcode;

  assign w_opcode = r_ir[OP_MSB:OP_LSB];

  always_comb begin
    w_state_next = r_state;
    w_ir_load    = 1'b0;
    w_jump_load  = 1'b0;
    w_jump_next  = bus.exec_result;
    w_pc_sel     = PC_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (run) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.rom_valid) begin
          w_ir_load    = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_opcode == OP_HALT) begin
          w_state_next = ST_HALT;
        end else if (w_opcode == OP_NOP) begin
          w_state_next = ST_UPDATE;
`ifdef FDE_DIRECT_JUMP_EN
        end else if (w_opcode == OP_JMP) begin
          w_jump_load  = 1'b1;
          w_jump_next  = PC_W'(r_ir[ARG1_MSB:ARG1_LSB]);
          w_state_next = ST_UPDATE;
`endif
        end else begin
          w_state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (bus.exec_done) begin
          w_jump_load  = 1'b1;
          w_state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_pc_sel     = (w_opcode == OP_JMP) ? PC_JUMP : PC_INC;
        w_state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ir         <= '0;
      r_jump       <= '0;
      r_exec_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_ir_load)   r_ir   <= bus.rom_data;
      if (w_jump_load) r_jump <= w_jump_next;
      // Marks only the first EXECUTE cycle so exec_start is a single pulse
      r_exec_first <= (w_state_next == ST_EXECUTE) && (r_state != ST_EXECUTE);
    end
  end

  fde_pc_unit #(
    .PC_W (PC_W)
  ) u_pc (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_sel   (w_pc_sel),
    .i_jump  (r_jump),
    .o_pc    (pc)
  );

  assign bus.rom_req    = (r_state == ST_FETCH);
  assign bus.rom_addr   = pc;
  assign bus.exec_start = (r_state == ST_EXECUTE) && r_exec_first;
  assign bus.opcode     = w_opcode;
  assign bus.arg1       = r_ir[ARG1_MSB:ARG1_LSB];
  assign bus.arg2       = r_ir[ARG2_MSB:ARG2_LSB];

  assign halted = (r_state == ST_HALT);
  assign busy   = (r_state == ST_FETCH)   || (r_state == ST_DECODE) ||
                  (r_state == ST_EXECUTE) || (r_state == ST_UPDATE);

endmodule

// File: tb/tb_fde_sequencer.sv
// Directed self-checking bench for fde_sequencer with a behavioural ROM and
// a programmable-latency execute unit.
module tb_fde_sequencer;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [15:0] pc;
  logic        halted;
  logic        busy;

  fde_sequencer_if #(.PC_W(16), .INSTR_W(40), .OP_W(8)) ifc ();

  fde_sequencer #(
    .PC_W    (16),
    .INSTR_W (40),
    .OP_W    (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .bus     (ifc.master),
    .pc      (pc),
    .halted  (halted),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [39:0] mem [logic [15:0]];
  logic [39:0] rom_data_r;
  logic        rom_stall;
  logic        force_valid;
  logic        force_done;
  int          exec_delay;
  logic [15:0] exec_result_r;
  logic        exec_busy;
  int          exec_cnt;
  logic [15:0] fetch_q [$];
  int          n_start;
  int          n_pass;
  int          n_total;

  always @(negedge clock) begin
    rom_data_r = mem.exists(ifc.rom_addr) ? mem[ifc.rom_addr] : 40'h0;
  end

  assign ifc.rom_data    = rom_data_r;
  assign ifc.rom_valid   = (ifc.rom_req & ~rom_stall) | force_valid;
  assign ifc.exec_result = exec_result_r;
  assign ifc.exec_done   = force_done | (ifc.exec_start && exec_delay == 0) |
                           (exec_busy && exec_cnt == exec_delay);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exec_busy <= 1'b0;
      exec_cnt  <= 0;
    end else if (ifc.exec_start && !ifc.exec_done) begin
      exec_busy <= 1'b1;
      exec_cnt  <= 1;
    end else if (exec_busy) begin
      if (ifc.exec_done) exec_busy <= 1'b0;
      else               exec_cnt  <= exec_cnt + 1;
    end
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      fetch_q.delete();
      n_start = 0;
    end else begin
      if (ifc.rom_req && ifc.rom_valid) fetch_q.push_back(ifc.rom_addr);
      if (ifc.exec_start) n_start = n_start + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    run         = 1'b0;
    rom_stall   = 1'b0;
    force_valid = 1'b0;
    force_done  = 1'b0;
    exec_delay  = 0;
    exec_result_r = 16'h0;
    mem.delete();
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    do_reset();

    // Reset state
    check("rst_rom_req", 40'(ifc.rom_req), 40'd0);
    check("rst_pc", 40'(pc), 40'd0);
    check("rst_halted", 40'(halted), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_exec_start", 40'(ifc.exec_start), 40'd0);
    check("rst_opcode", 40'(ifc.opcode), 40'd0);

    // NOP stream 0..2: 1 idle + 3 cycles per NOP
    run = 1'b1;
    step(9);
    check("nop_pc_9", 40'(pc), 40'd2);
    step(1);
    check("nop_pc_10", 40'(pc), 40'd3);
    check("nop_rom_req", 40'(ifc.rom_req), 40'd1);
    check("nop_rom_addr", 40'(ifc.rom_addr), 40'd3);
    check("nop_fetch_cnt", 40'(fetch_q.size()), 40'd3);
    if (fetch_q.size() >= 3) begin
      check("nop_fetch0", 40'(fetch_q[0]), 40'h0);
      check("nop_fetch1", 40'(fetch_q[1]), 40'h1);
      check("nop_fetch2", 40'(fetch_q[2]), 40'h2);
    end
    check("nop_no_start", 40'(n_start), 40'd0);

    // Generic op with 3-cycle exec, then NOP, then HALT at 2
    do_reset();
    mem[16'h0000] = 40'h01_0005_0007;
    mem[16'h0002] = 40'hFF_1234_5678;
    exec_delay = 3;
    run = 1'b1;
    step(3);
    check("gen_start", 40'(ifc.exec_start), 40'd1);
    check("gen_opcode", 40'(ifc.opcode), 40'h01);
    check("gen_arg1", 40'(ifc.arg1), 40'h0005);
    check("gen_arg2", 40'(ifc.arg2), 40'h0007);
    step(1);
    check("gen_start_pulse", 40'(ifc.exec_start), 40'd0);
    check("gen_opcode_hold", 40'(ifc.opcode), 40'h01);
    step(3);
    check("gen_pc_before", 40'(pc), 40'd0);
    step(1);
    check("gen_pc_after", 40'(pc), 40'd1);
    check("gen_one_start", 40'(n_start), 40'd1);
    step(5);
    check("halt_halted", 40'(halted), 40'd1);
    check("halt_pc", 40'(pc), 40'd2);
    check("halt_busy", 40'(busy), 40'd0);
    step(10);
    check("halt_sticky", 40'(halted), 40'd1);
    check("halt_pc_hold", 40'(pc), 40'd2);
    check("halt_no_req", 40'(ifc.rom_req), 40'd0);
    reset_n = 1'b0;
    #1;
    check("halt_reset_clr", 40'(halted), 40'd0);

    // JMP at 4 to 0x0020
    do_reset();
    mem[16'h0004] = 40'h09_0020_0000;
    mem[16'h0020] = 40'hFF_0000_0000;
    exec_result_r = 16'h0020;
    exec_delay = 0;
    run = 1'b1;
    step(16);
`ifdef FDE_DIRECT_JUMP_EN
    check("jmp_pc_16", 40'(pc), 40'h0020);
`else
    check("jmp_pc_16", 40'(pc), 40'h0004);
`endif
    step(1);
    check("jmp_pc_17", 40'(pc), 40'h0020);
    check("jmp_rom_addr", 40'(ifc.rom_addr), 40'h0020);
`ifdef FDE_DIRECT_JUMP_EN
    check("jmp_starts", 40'(n_start), 40'd0);
`else
    check("jmp_starts", 40'(n_start), 40'd1);
`endif

    // Jump to 0xFFFF, NOP there wraps to 0x0000; stop after third fetch
    do_reset();
    mem[16'h0000] = 40'h09_FFFF_0000;
    exec_result_r = 16'hFFFF;
    run = 1'b1;
    for (int i = 0; i < 40 && fetch_q.size() < 3; i++) step(1);
    check("wrap_fetch_cnt", 40'(fetch_q.size()), 40'd3);
    run = 1'b0;
    if (fetch_q.size() >= 3) begin
      check("wrap_fetch1", 40'(fetch_q[1]), 40'hFFFF);
      check("wrap_fetch2", 40'(fetch_q[2]), 40'h0000);
    end
    step(6);
    check("wrap_idle", 40'(busy), 40'd0);
    check("wrap_pc", 40'(pc), 40'hFFFF);

    // run dropped during EXECUTE
    do_reset();
    mem[16'h0000] = 40'h05_1234_5678;
    exec_delay = 2;
    exec_result_r = 16'h00AA;
    run = 1'b1;
    step(3);
    check("stop_start", 40'(ifc.exec_start), 40'd1);
    run = 1'b0;
    step(4);
    check("stop_pc", 40'(pc), 40'd1);
    check("stop_busy", 40'(busy), 40'd0);
    check("stop_halted", 40'(halted), 40'd0);
    check("stop_arg2", 40'(ifc.arg2), 40'h5678);

    // Stray rom_valid / exec_done while idle are ignored
    force_valid = 1'b1;
    force_done  = 1'b1;
    step(3);
    check("stray_req", 40'(ifc.rom_req), 40'd0);
    check("stray_busy", 40'(busy), 40'd0);
    check("stray_pc", 40'(pc), 40'd1);
    check("stray_opcode", 40'(ifc.opcode), 40'h05);
    force_valid = 1'b0;
    force_done  = 1'b0;

    // Asynchronous reset in the middle of a stalled fetch
    rom_stall = 1'b1;
    run = 1'b1;
    step(2);
    check("arst_req_before", 40'(ifc.rom_req), 40'd1);
    check("arst_addr_before", 40'(ifc.rom_addr), 40'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", 40'(ifc.rom_req), 40'd0);
    check("arst_pc", 40'(pc), 40'd0);
    check("arst_busy", 40'(busy), 40'd0);
    check("arst_opcode", 40'(ifc.opcode), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
